// File: rtl/sd_fifo_arb_pkg.sv
// Shared types for the sd_fifo_arb round-robin arbiter.
// No logic; lock state encodings used by the optional packet-lock FSM.
// Backpressure: n/a.
package sd_fifo_arb_pkg;

    // Packet-lock state: IDLE lets every producer compete, LOCK pins one owner.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } lock_st_t;

endpackage

// File: rtl/sd_fifo_arb_rr_pick.sv
// Round-robin picker: first requester after 'last' (wrapping), restricted by mask.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module sd_rr_pick #(
    parameter int inputs = 4,
    parameter int isz    = 2
) (
    input  logic [inputs-1:0] req,
    input  logic [inputs-1:0] mask,
    input  logic [isz-1:0]    last,
    output logic [inputs-1:0] gnt_onehot,
    output logic [isz-1:0]    gnt_idx,
    output logic              any
);

    // Scan last+1 .. last+inputs modulo inputs; the first eligible requester wins.
    always_comb begin
        int k;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        k          = 0;
        for (int off = 1; off <= inputs; off++) begin
            k = (int'(last) + off) % inputs;
            if (!any && req[k] && mask[k]) begin
                any           = 1'b1;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = isz'(k);
            end
        end
    end

endmodule

// File: rtl/sd_fifo_arb.sv
// N-producer round-robin arbiter feeding one registered srdy/drdy output stage.
// Latency: 1 clk from input transfer to p_srdy; one word per cycle when p_drdy=1.
// Backpressure: output stage holds while p_srdy&!p_drdy and all c_drdy drop to 0.
// Optional packet lock (bit width-1 = EOP) enabled by macro SD_FIFO_ARB_PKT_EN.
module sd_fifo_arb
    import sd_fifo_arb_pkg::*;
#(
    parameter int width  = 8,
    parameter int inputs = 4,
    parameter int isz    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic [isz-1:0]          p_grant
);

    logic              p_srdy_q, p_srdy_d;
    logic [width-1:0]  p_data_q, p_data_d;
    logic [isz-1:0]    p_grant_q, p_grant_d;
    logic [isz-1:0]    last_q, last_d;

    logic              ld;
    logic              xfer;
    logic [inputs-1:0] mask;
    logic [inputs-1:0] gnt_onehot;
    logic [isz-1:0]    gnt_idx;
    logic              any;
    logic [width-1:0]  word;

    // Output stage can accept when empty or when its word leaves this cycle.
    assign ld   = !p_srdy_q || p_drdy;
    assign xfer = ld && any;
    assign word = c_data[int'(gnt_idx)*width +: width];

    sd_rr_pick #(
        .inputs (inputs),
        .isz    (isz)
    ) u_pick (
        .req        (c_srdy),
        .mask       (mask),
        .last       (last_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Ready goes only to the picked producer, never while reset is held.
    assign c_drdy = (reset && ld) ? gnt_onehot : '0;

`ifdef SD_FIFO_ARB_PKT_EN
    lock_st_t       st_q, st_d;
    logic [isz-1:0] own_q, own_d;

    // Lock FSM: a non-EOP word opens a packet, the owner's EOP word closes it.
    always_comb begin
        st_d  = st_q;
        own_d = own_q;
        mask  = '1;
        case (st_q)
            ST_IDLE: begin
                if (xfer && !word[width-1]) begin
                    st_d  = ST_LOCK;
                    own_d = gnt_idx;
                end
            end
            ST_LOCK: begin
                mask         = '0;
                mask[own_q]  = 1'b1;
                if (xfer && word[width-1]) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= ST_IDLE;
            own_q <= '0;
        end else begin
            st_q  <= st_d;
            own_q <= own_d;
        end
    end
`else
    assign mask = '1;
`endif

    // Output stage / pointer next state: load on transfer, empty when nothing to load.
    always_comb begin
        p_srdy_d  = p_srdy_q;
        p_data_d  = p_data_q;
        p_grant_d = p_grant_q;
        last_d    = last_q;
        if (ld) begin
            if (any) begin
                p_srdy_d  = 1'b1;
                p_data_d  = word;
                p_grant_d = gnt_idx;
                last_d    = gnt_idx;
            end else begin
                p_srdy_d  = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer; producer 0 has first priority after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_srdy_q  <= 1'b0;
            p_data_q  <= '0;
            p_grant_q <= '0;
            last_q    <= isz'(inputs - 1);
        end else begin
            p_srdy_q  <= p_srdy_d;
            p_data_q  <= p_data_d;
            p_grant_q <= p_grant_d;
            last_q    <= last_d;
        end
    end

    assign p_srdy  = p_srdy_q;
    assign p_data  = p_data_q;
    assign p_grant = p_grant_q;

endmodule

// File: tb/tb_sd_fifo_arb.sv
module tb_sd_fifo_arb;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int ISZ = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   c_srdy = '0;
    logic [N-1:0]   c_drdy;
    logic [N*W-1:0] c_data = '0;
    logic           p_srdy;
    logic           p_drdy = 1'b0;
    logic [W-1:0]   p_data;
    logic [ISZ-1:0] p_grant;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one-deep output buffer, rr pointer, packet owner (-1 = none).
    bit           m_vld;
    logic [W-1:0] m_dat;
    int           m_gnt;
    int           m_last;
    int           m_lock;

    // Results of the most recent cycle, for stimulus bookkeeping.
    int           cyc_k;
    bit           pop_vld;
    logic [W-1:0] pop_dat;

    sd_fifo_arb #(.width(W), .inputs(N), .isz(ISZ)) dut (
        .clk     (clk),
        .reset   (reset),
        .c_srdy  (c_srdy),
        .c_drdy  (c_drdy),
        .c_data  (c_data),
        .p_srdy  (p_srdy),
        .p_drdy  (p_drdy),
        .p_data  (p_data),
        .p_grant (p_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int k);
        return c_data[k*W +: W];
    endfunction

    task automatic model_reset();
        m_vld  = 1'b0;
        m_dat  = '0;
        m_gnt  = 0;
        m_last = N - 1;
        m_lock = -1;
    endtask

    // Called just after a posedge; asserts reset, checks async clear, releases off-edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_p_srdy", p_srdy, 0);
        chk("rst_p_data", p_data, 0);
        chk("rst_p_grant", p_grant, 0);
        chk("rst_c_drdy", c_drdy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One clock: check c_drdy before the edge, advance the model, check outputs after.
    task automatic cycle();
        int           k;
        int           kk;
        bit           ld;
        logic [N-1:0] exp_drdy;
        @(negedge clk);
        ld = !m_vld || p_drdy;
        k  = -1;
        if (ld) begin
            for (int o = 1; o <= N; o++) begin
                kk = (m_last + o) % N;
                if (k < 0 && c_srdy[kk] && (m_lock < 0 || m_lock == kk)) k = kk;
            end
        end
        exp_drdy = '0;
        if (k >= 0) exp_drdy[k] = 1'b1;
        chk("c_drdy", c_drdy, exp_drdy);
        pop_vld = m_vld && p_drdy;
        pop_dat = p_data;
        @(posedge clk);
        if (ld) begin
            if (k >= 0) begin
                m_vld  = 1'b1;
                m_dat  = word_of(k);
                m_gnt  = k;
                m_last = k;
`ifdef SD_FIFO_ARB_PKT_EN
                if (m_lock < 0 && !m_dat[W-1]) m_lock = k;
                else if (m_lock == k && m_dat[W-1]) m_lock = -1;
`endif
            end else begin
                m_vld = 1'b0;
            end
        end
        cyc_k = k;
        #1;
        chk("p_srdy", p_srdy, m_vld);
        chk("p_data", p_data, m_dat);
        chk("p_grant", p_grant, m_gnt);
    endtask

    initial begin
        int           exp_pkt[5];
        int           rem[N];
        int           sent1;
        logic [W-1:0] hold;
        logic [7:0]   pat_s;
        logic [7:0]   pat_d;
        logic [W-1:0] seq_tx;
        logic [W-1:0] seq_rx;
        int           n_rx;

        model_reset();
        @(posedge clk);
        #1;

        // All four requesting, downstream always ready: 0,1,2,3,0.
        c_srdy = 4'b1111;
        p_drdy = 1'b1;
        c_data = 32'h31_21_11_01;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq", p_grant, i % N);
            if (i == 0) chk("first_vld", p_srdy, 1);
        end

        // Backpressure for 10 cycles with 0 and 2 requesting.
        c_srdy = 4'b0001;
        do_reset();
        cycle();
        hold   = p_data;
        c_srdy = 4'b0101;
        p_drdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_data", p_data, hold);
            chk("stall_vld", p_srdy, 1);
        end
        p_drdy = 1'b1;
        cycle();
        chk("stall_next", p_grant, 2);

        // Reset mid-stream with p_srdy high.
        chk("pre_rst_vld", p_srdy, 1);
        c_srdy = 4'b1010;
        do_reset();
        cycle();
        chk("rst_first", p_grant, 1);

        // Producer 1 sends a 3-word packet while 0 and 2 keep requesting.
`ifdef SD_FIFO_ARB_PKT_EN
        exp_pkt = '{1, 1, 1, 2, 0};
`else
        exp_pkt = '{1, 2, 0, 1, 2};
`endif
        c_srdy = 4'b0001;
        c_data = 32'h00_00_00_80;
        do_reset();
        cycle();
        rem   = '{100, 3, 100, 0};
        sent1 = 0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N; k++) c_srdy[k] = (rem[k] > 0);
            c_data[0*W +: W] = 8'h80;
            c_data[2*W +: W] = 8'h82;
            c_data[3*W +: W] = 8'h83;
            c_data[1*W +: W] = (sent1 == 2) ? 8'h93 : (8'h11 + 8'(sent1));
            cycle();
            chk("pkt_seq", p_grant, exp_pkt[i]);
            if (cyc_k >= 0) begin
                rem[cyc_k]--;
                if (cyc_k == 1) sent1++;
            end
        end

        // Only producer 3, patterned srdy and drdy: in-order, gap-free data.
        c_srdy = '0;
        do_reset();
        pat_s  = 8'h5A;
        pat_d  = 8'hA5;
        seq_tx = '0;
        seq_rx = '0;
        n_rx   = 0;
        for (int i = 0; i < 200; i++) begin
            c_srdy           = {pat_s[7], 3'b000};
            c_data           = {seq_tx, 24'h0};
            p_drdy           = pat_d[7];
            pat_s            = {pat_s[6:0], pat_s[7]};
            pat_d            = {pat_d[6:0], pat_d[7]};
            cycle();
            if (cyc_k == 3) seq_tx++;
            if (pop_vld) begin
                chk("seq_order", pop_dat, seq_rx);
                seq_rx++;
                n_rx++;
            end
        end
        chk("seq_count", (n_rx > 20), 1);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            c_srdy = 4'($urandom);
            c_data = $urandom;
            p_drdy = ($urandom_range(0, 3) != 0);
            cycle();
            if ((i % 700) == 699) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_fifo_arb.md
Name: sd_fifo_arb

Overview:
- Round-robin arbiter that shares one srdy/drdy consumer port (typically the c_ side of sd_fifo_s) among N independent producers.
- Selects one requesting producer per cycle and moves its word into a registered output stage; the output stage drives the shared FIFO.
- Sits between sd_seq_gen-style sources and a single sd_fifo_s.
- Sustains one transfer per cycle when the downstream is always ready.

Parameters:
- width, 8, data bits per word
- inputs, 4, number of producer ports (2..16)
- isz, 2, bits of source index; must satisfy 2**isz >= inputs

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- c_srdy  input  inputs  per-producer source ready
- c_drdy  output  inputs  per-producer destination ready; at most one bit high per cycle
- c_data  input  inputs*width  producer words; producer i occupies bits [i*width +: width]
- p_srdy  output  1  output stage holds valid word
- p_drdy  input  1  downstream (FIFO c_drdy) ready
- p_data  output  width  registered word
- p_grant  output  isz  index of the producer that supplied p_data

Behaviour:
- Reset (async, reset==0): p_srdy=0, p_data=0, p_grant=0, rr pointer last=inputs-1 (producer 0 has first priority), lock state=IDLE. All c_drdy bits are 0 while reset is held.
- Reset mid-operation discards the held word. After deassertion, the first grant goes to the lowest-numbered requester.
- Output stage load enable: ld = !p_srdy || p_drdy. This is combinational and allows pass-through and refill in the same cycle.
- Pick: search indices last+1 .. last+inputs (mod inputs) and take the first with c_srdy=1. Eligibility is restricted by the lock state (see Optional Feature).
- c_drdy[k]=1 iff ld and k is the picked index. Transfer on producer k occurs when c_srdy[k]&c_drdy[k].
- On a transfer: p_data<=word k, p_grant<=k, p_srdy<=1, last<=k. Latency is 1 clk from input transfer to p_srdy.
- If ld and no requester: p_srdy<=0. p_data and p_grant hold their previous values.
- If p_srdy and !p_drdy: the output stage holds and every c_drdy is 0. There is no drop and no overwrite.
- Simultaneous p_drdy=1 and new request: the old word leaves and the new word loads in the same edge.
- Wrap-around: when last=inputs-1, the search starts at 0. Indices >= inputs never win.
- Fairness: with all inputs requesting continuously, grants cycle 0,1,...,inputs-1,0,...
- c_drdy depends combinationally on c_srdy and p_drdy. p_srdy, p_data and p_grant are pure flops.

Optional Feature:
- Macro SD_FIFO_ARB_PKT_EN.
- Defined: packet lock. Bit width-1 of each word is end-of-packet (EOP).
  - State IDLE: all inputs are eligible. A transfer with EOP=0 from k moves to LOCKED(k).
  - State LOCKED(k): only producer k is eligible; others see c_drdy=0 even if the output stage is empty. A transfer from k with EOP=1 returns to IDLE and sets last<=k.
  - Single-word packets (EOP=1 in IDLE) stay in IDLE.
  - Reset forces IDLE.
- Undefined: no lock. Bit width-1 is ordinary data, and arbitration rotates after every word.

Decomposition:
- Shared constants include (sd_fifo_arb_defs.vh): lock state encodings ST_IDLE=1'b0 and ST_LOCK=1'b1; macro default notes.
- One sub-module: sd_rr_pick (combinational). Inputs: req[inputs], mask[inputs], last[isz]. Outputs: gnt_onehot[inputs], gnt_idx[isz], any.
- The top level holds the output register, the last pointer and the lock FSM.

Test Plan:
- Reset released with c_srdy=4'b1111 and p_drdy=1 -> p_grant sequence 0,1,2,3,0 on consecutive cycles; first p_srdy=1 one clk after the first transfer.
- p_drdy held 0 for 10 cycles with c_srdy=4'b0101 -> p_srdy stays 1 and p_data is unchanged; c_drdy=0 every cycle. p_drdy then returns to 1 -> next grant is 2 if last=0.
- Only producer 3 requesting, with sd_seq_gen patterns 8'h5A on srdy and 8'hA5 on p_drdy -> sd_seq_check sees in-order data with no gaps or duplicates after 200 cycles.
- Reset pulled low mid-stream while p_srdy=1 -> p_srdy=0 immediately, without a clock edge. After release with c_srdy=4'b1010, first grant=1.
- With SD_FIFO_ARB_PKT_EN, producer 1 sends 3 words with EOP on the 3rd while 0 and 2 request -> p_grant=1,1,1 then 2, then 0.
- Without the macro, the same stimulus -> grants interleave 1,2,0,1,...
